// File: rtl/alu_pkg.sv
// Shared types for the 4-bit ALU and its command sequencer.
package alu_pkg;

    localparam int ALU_TAG_W = 4;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_DEC = 4'd6,
        OP_SHL = 4'd7
    } alu_op_e;

    typedef struct packed {
        logic [3:0]           a;
        logic [3:0]           b;
        alu_op_e              op;
        logic [ALU_TAG_W-1:0] tag;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_STALL,
        SEQ_DRAIN
    } seq_st_e;

    function automatic logic op_legal(alu_op_e op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_AND,
                          OP_OR, OP_XOR, OP_DEC, OP_SHL};
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; head reads as all-zero (OP_ADD) when empty.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  alu_cmd_t                 wdata,
    input  logic                     pop,
    output alu_cmd_t                 head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    alu_cmd_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    assign full  = (count == DEPTH[AW:0]);
    assign empty = (count == '0);
    assign head  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 4-bit ALU: buffers commands, presents the head to the
// external ALU, and registers each result with its tag for the consumer.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  alu_cmd_t               in_cmd,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output alu_op_e                alu_opcode,
    input  logic [7:0]             alu_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_result,
    output logic [ALU_TAG_W-1:0]   out_tag,
    output logic                   out_err,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [CNT_W-1:0]       issued_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    alu_cmd_t      head;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          issue;
    logic          legal;
    logic [CW-1:0] nxt_cnt;
    logic          nxt_ov;
    seq_st_e       st;
    seq_st_e       st_d;

    assign in_ready   = !full;
    assign push       = in_valid && in_ready;
    assign issue      = !empty && (!out_valid || out_ready);
    assign legal      = op_legal(head.op);
    assign fifo_count = count;
    assign alu_a      = head.a;
    assign alu_b      = head.b;
    assign alu_opcode = head.op;

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_cmd),
        .pop   (issue),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_err    <= 1'b0;
            issued_cnt <= '0;
        end else if (issue) begin
            out_valid  <= 1'b1;
            out_result <= legal ? alu_result : 8'h00;
            out_tag    <= head.tag;
            out_err    <= !legal;
            issued_cnt <= issued_cnt + 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Status FSM looks ahead at post-edge occupancy; it drives nothing.
    always_comb begin
        nxt_cnt = count;
        if (push && !issue) begin
            nxt_cnt = count + 1'b1;
        end else if (issue && !push) begin
            nxt_cnt = count - 1'b1;
        end
        nxt_ov = issue || (out_valid && !out_ready);
        if (nxt_cnt == '0) begin
            st_d = nxt_ov ? SEQ_DRAIN : SEQ_IDLE;
        end else if (!nxt_ov || out_ready) begin
            st_d = SEQ_RUN;
        end else begin
            st_d = SEQ_STALL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= SEQ_IDLE;
        end else begin
            st <= st_d;
        end
    end

    st_idle_ok: assert property (@(posedge clk) disable iff (rst)
        (st == SEQ_IDLE) |-> (empty && !out_valid));

    st_drain_ok: assert property (@(posedge clk) disable iff (rst)
        (st == SEQ_DRAIN) |-> (empty && out_valid));

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a queue-level reference model
// and a reference ALU driving alu_result.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    alu_cmd_t             in_cmd;
    logic [3:0]           alu_a;
    logic [3:0]           alu_b;
    alu_op_e              alu_opcode;
    logic [7:0]           alu_result;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           out_result;
    logic [ALU_TAG_W-1:0] out_tag;
    logic                 out_err;
    logic [2:0]           fifo_count;
    logic [15:0]          issued_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] res;
        logic [3:0] tag;
        logic       err;
    } out_t;

    alu_cmd_t   m_q[$];
    logic       s_valid;
    out_t       s_out;
    int         m_issued;
    out_t       out_log[$];

    alu_cmd_sequencer #(.DEPTH(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cmd     (in_cmd),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_err    (out_err),
        .fifo_count (fifo_count),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(logic [3:0] a, logic [3:0] b,
                                          logic [3:0] op);
        case (op)
            4'd0:    return {4'h0, a} + {4'h0, b};
            4'd1:    return {4'h0, a - b};
            4'd2:    return {4'h0, a} * {4'h0, b};
            4'd3:    return {4'h0, a & b};
            4'd4:    return {4'h0, a | b};
            4'd5:    return {4'h0, a ^ b};
            4'd6:    return 8'd1 << a[2:0];
            4'd7:    return {4'h0, a} << b[1:0];
            default: return 8'h00;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_a, alu_b, alu_opcode);

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a pending queue plus one output slot.
    always @(posedge clk or posedge rst) begin : model
        alu_cmd_t c;
        logic     acc;
        logic     iss;
        if (rst) begin
            m_q.delete();
            s_valid  = 1'b0;
            s_out    = '{res: 8'h00, tag: 4'h0, err: 1'b0};
            m_issued = 0;
        end else begin
            acc = in_valid && (m_q.size() < 4);
            iss = (m_q.size() > 0) && (!s_valid || out_ready);
            if (s_valid && out_ready) begin
                out_log.push_back(s_out);
            end
            if (iss) begin
                c = m_q.pop_front();
                s_valid   = 1'b1;
                s_out.err = (4'(c.op) > 4'd7);
                s_out.res = s_out.err ? 8'h00 : alu_fn(c.a, c.b, 4'(c.op));
                s_out.tag = c.tag;
                m_issued++;
            end else if (s_valid && out_ready) begin
                s_valid = 1'b0;
            end
            if (acc) begin
                m_q.push_back(in_cmd);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", 32'(in_ready), 32'(m_q.size() < 4));
            check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
            check("out_valid", 32'(out_valid), 32'(s_valid));
            check("issued_cnt", 32'(issued_cnt), 32'(m_issued[15:0]));
            if (s_valid) begin
                check("out_result", 32'(out_result), 32'(s_out.res));
                check("out_tag", 32'(out_tag), 32'(s_out.tag));
                check("out_err", 32'(out_err), 32'(s_out.err));
            end
            if (m_q.size() > 0) begin
                check("alu_a", 32'(alu_a), 32'(m_q[0].a));
                check("alu_b", 32'(alu_b), 32'(m_q[0].b));
                check("alu_op", 32'(alu_opcode), 32'(m_q[0].op));
            end else begin
                check("alu_a_idle", 32'(alu_a), 32'h0);
                check("alu_op_idle", 32'(alu_opcode), 32'(OP_ADD));
            end
        end
    end

    task automatic send(logic [3:0] a, logic [3:0] b,
                        logic [3:0] op, logic [3:0] tag);
        logic acc;
        int   n;
        in_valid = 1'b1;
        in_cmd   = '{a: a, b: b, op: alu_op_e'(op), tag: tag};
        n = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(posedge clk);
            acc = in_ready;
            n++;
        end
        #1 in_valid = 1'b0;
        if (!acc) begin
            check("send_timeout", 32'd0, 32'd1);
        end
    endtask

    // Asserts reset mid-cycle and checks the asynchronous effect at once.
    task automatic do_reset();
        #3 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_issued_cnt", 32'(issued_cnt), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_log(int n, string name);
        int k;
        k = 0;
        while (out_log.size() < n && k < 300) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (out_log.size() < n) begin
            check(name, 32'(out_log.size()), 32'(n));
        end
    endtask

    logic [7:0] exp4_res [4] = '{8'hE1, 8'h0E, 8'h04, 8'h08};
    logic [3:0] exp4_tag [4] = '{4'd2, 4'd3, 4'd4, 4'd5};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_cmd    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single ADD with two-edge latency
        out_ready = 1'b1;
        send(4'd9, 4'd8, 4'd0, 4'd1);
        @(negedge clk);
        check("lat_e0_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_e1_valid", 32'(out_valid), 32'd1);
        check("add_result", 32'(out_result), 32'h11);
        check("add_tag", 32'(out_tag), 32'd1);
        @(posedge clk);
        #1;

        // Backpressure fills the FIFO
        do_reset();
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(4'(i), 4'd1, 4'd0, 4'(i));
                end
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                check("full_count", 32'(fifo_count), 32'd4);
                check("full_in_ready", 32'(in_ready), 32'd0);
                check("full_out_tag", 32'(out_tag), 32'd0);
                check("full_issued", 32'(issued_cnt), 32'd1);
                out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        check("drain_issued", 32'(issued_cnt), 32'd6);

        // Mixed stream with random consumer stalls
        do_reset();
        out_log.delete();
        fork
            begin
                send(4'd15, 4'd15, 4'd2, 4'd2);
                send(4'd3, 4'd5, 4'd1, 4'd3);
                send(4'd2, 4'd0, 4'd6, 4'd4);
                send(4'd12, 4'd10, 4'd3, 4'd5);
            end
            begin
                for (int k = 0; k < 300 && out_log.size() < 4; k++) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_log(4, "stream_timeout");
        check("stream_count", 32'(out_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < out_log.size(); i++) begin
            check("stream_res", 32'(out_log[i].res), 32'(exp4_res[i]));
            check("stream_tag", 32'(out_log[i].tag), 32'(exp4_tag[i]));
        end
        check("stream_issued", 32'(issued_cnt), 32'd4);

        // Illegal opcode then a legal one
        do_reset();
        out_log.delete();
        out_ready = 1'b1;
        send(4'd5, 4'd3, 4'd9, 4'd7);
        send(4'd5, 4'd3, 4'd0, 4'd8);
        wait_log(2, "illegal_timeout");
        if (out_log.size() >= 2) begin
            check("illegal_res", 32'(out_log[0].res), 32'h00);
            check("illegal_err", 32'(out_log[0].err), 32'd1);
            check("illegal_tag", 32'(out_log[0].tag), 32'd7);
            check("legal_res", 32'(out_log[1].res), 32'h08);
            check("legal_err", 32'(out_log[1].err), 32'd0);
        end
        check("illegal_issued", 32'(issued_cnt), 32'd2);

        // Reset discards queued and in-flight work
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(4'd1, 4'(i), 4'd4, 4'(i));
        end
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_count", 32'(fifo_count), 32'd3);
        do_reset();
        out_log.delete();
        out_ready = 1'b1;
        send(4'd1, 4'd1, 4'd0, 4'd9);
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_count", 32'(out_log.size()), 32'd1);
        if (out_log.size() >= 1) begin
            check("post_rst_res", 32'(out_log[0].res), 32'h02);
            check("post_rst_tag", 32'(out_log[0].tag), 32'd9);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
